timer_apb_regs: RTL and testbench

APB slave register block for the 8-bit timer. It is the initiator side of the counter control interface. It converts bus writes into the counter controls: start_counter, up_down, enable, load, clock select, and the overflow/underflow clear pulses. It also returns counter value and status on bus reads. It sits between the APB fabric and the counter/prescaler pair.

---
 rtl/timer_pkg.sv | 30 +++
 rtl/timer_apb_fsm.sv | 71 +++++++
 rtl/timer_apb_regs.sv | 114 +++++++++++
 tb/tb_timer_apb_regs.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the 8-bit timer APB register block.
// No logic: register offsets, bit positions and bus FSM encodings only.
// Imported by timer_apb_fsm and timer_apb_regs.
package timer_pkg;

  // Register offsets (low two address bits; upper bits must be zero)
  localparam logic [1:0] TDR_ADDR  = 2'd0;
  localparam logic [1:0] TCR_ADDR  = 2'd1;
  localparam logic [1:0] TSR_ADDR  = 2'd2;
  localparam logic [1:0] TCNT_ADDR = 2'd3;

  // TCR bit positions
  localparam int LOAD_BIT = 7;
  localparam int UPDN_BIT = 5;
  localparam int EN_BIT   = 4;
  localparam int CS_MSB   = 1;
  localparam int CS_LSB   = 0;

  // TSR bit positions
  localparam int OVF_BIT = 0;
  localparam int UDF_BIT = 1;

  // APB slave phase tracking
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/timer_apb_fsm.sv
// APB slave phase tracker: IDLE/SETUP/ACCESS, wait-state counter, pready/complete.
// pready rises WAIT_CYCLES cycles into ACCESS (first ACCESS cycle when 0).
// Holds pready low to stall the master; dropping psel abandons the transfer.
module timer_apb_fsm
  import timer_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic complete
);

  localparam logic [2:0] WAIT_L = 3'(WAIT_CYCLES);

  apb_state_e state;
  logic [2:0] wcnt;

  // Phase tracking with a registered pready so it is glitch-free on the bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      wcnt   <= 3'd0;
      pready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wcnt   <= 3'd0;
          pready <= 1'b0;
          if (psel && !penable) state <= SETUP;
        end
        SETUP: begin
          wcnt <= 3'd0;
          if (psel) begin
            state  <= ACCESS;
            pready <= (WAIT_L == 3'd0);
          end else begin
            state  <= IDLE;
            pready <= 1'b0;
          end
        end
        ACCESS: begin
          if (pready) begin
            // Completing cycle: a fresh setup phase may already be on the bus
            wcnt   <= 3'd0;
            pready <= 1'b0;
            state  <= (psel && !penable) ? SETUP : IDLE;
          end else if (!psel) begin
            wcnt  <= 3'd0;
            state <= IDLE;
          end else begin
            wcnt <= wcnt + 3'd1;
            if ((wcnt + 3'd1) == WAIT_L) pready <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          wcnt   <= 3'd0;
          pready <= 1'b0;
        end
      endcase
    end
  end

  // A transfer only retires while the master still selects us
  assign complete = pready && psel;

endmodule

// File: rtl/timer_apb_regs.sv
// APB register block for the 8-bit timer: TDR, TCR, TSR (w1c), TCNT (ro).
// Register effects at the completing edge, visible on outputs the next cycle.
// Wait states come from timer_apb_fsm; bad offsets or TCNT writes get pslverr.
module timer_apb_regs
  import timer_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              clk_ena,
  input  logic [7:0]        tcnt,
  input  logic              overflow,
  input  logic              underflow,
  output logic [7:0]        start_counter,
  output logic              up_down,
  output logic              enable,
  output logic [1:0]        clk_sel,
  output logic              load,
  output logic              clr_overflow,
  output logic              clr_underflow
);

  localparam logic [ADDR_W-1:0] REG_SPAN = ADDR_W'(4);

  logic       complete;
  logic [1:0] reg_sel;
  logic       addr_err;
  logic       wr_ok;
  logic       rd_ok;
  logic [7:0] rdata;

  timer_apb_fsm #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .psel    (psel),
    .penable (penable),
    .pready  (pready),
    .complete(complete)
  );

  assign reg_sel  = paddr[1:0];
  assign addr_err = (paddr >= REG_SPAN) || (pwrite && (reg_sel == TCNT_ADDR));
  assign wr_ok    = complete && pwrite && !addr_err;
  assign rd_ok    = pready && !pwrite && !addr_err;

  // Read mux; reserved bits read as zero
  always_comb begin
    rdata = 8'h00;
    case (reg_sel)
      TDR_ADDR:  rdata = start_counter;
      TCR_ADDR: begin
        rdata[LOAD_BIT]      = load;
        rdata[UPDN_BIT]      = up_down;
        rdata[EN_BIT]        = enable;
        rdata[CS_MSB:CS_LSB] = clk_sel;
      end
      TSR_ADDR: begin
        rdata[OVF_BIT] = overflow;
        rdata[UDF_BIT] = underflow;
      end
      default:   rdata = tcnt;
    endcase
  end

  assign prdata  = rd_ok ? rdata : 8'h00;
  assign pslverr = pready && addr_err;

  // Control registers, load handshake and one-shot clear pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_counter <= 8'h00;
      up_down       <= 1'b0;
      enable        <= 1'b0;
      clk_sel       <= 2'b00;
      load          <= 1'b0;
      clr_overflow  <= 1'b0;
      clr_underflow <= 1'b0;
    end else begin
      clr_overflow  <= 1'b0;
      clr_underflow <= 1'b0;

      if (wr_ok && reg_sel == TDR_ADDR) start_counter <= pwdata;

      if (wr_ok && reg_sel == TCR_ADDR) begin
        up_down <= pwdata[UPDN_BIT];
        enable  <= pwdata[EN_BIT];
        clk_sel <= pwdata[CS_MSB:CS_LSB];
      end

      // A setting write wins over a coincident tick, so load always lasts at
      // least one cycle; writing bit 7 = 0 leaves a pending load alone.
      if (wr_ok && reg_sel == TCR_ADDR && pwdata[LOAD_BIT]) load <= 1'b1;
      else if (load && clk_ena)                              load <= 1'b0;

      if (wr_ok && reg_sel == TSR_ADDR) begin
        clr_overflow  <= pwdata[OVF_BIT];
        clr_underflow <= pwdata[UDF_BIT];
      end
    end
  end

endmodule

// File: tb/tb_timer_apb_regs.sv
// Bench for timer_apb_regs: three instances (WAIT_CYCLES 0, 3, 2) on one bus.
// Table-driven APB transfers with a queue scoreboard, plus hand sequences.
// Each transfer waits for pready under a cycle bound.
module tb_timer_apb_regs;

  typedef struct {
    int         dut;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    bit         err;
    logic [1:0] clr;   // expected {clr_underflow, clr_overflow} after completion
  } vec_t;

  typedef struct {
    logic [7:0] rdata;
    bit         err;
    bit         cmp_rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] psel_v;
  logic       penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic       clk_ena, overflow, underflow;
  logic [7:0] tcnt;

  logic [7:0] prdata        [3];
  logic       pready        [3];
  logic       pslverr       [3];
  logic [7:0] start_counter [3];
  logic       up_down       [3];
  logic       enable        [3];
  logic [1:0] clk_sel       [3];
  logic       load          [3];
  logic       clr_ovf       [3];
  logic       clr_udf       [3];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      timer_apb_regs #(
        .WAIT_CYCLES(g == 1 ? 3 : (g == 2 ? 2 : 0)),
        .ADDR_W     (8)
      ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .psel         (psel_v[g]),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .prdata       (prdata[g]),
        .pready       (pready[g]),
        .pslverr      (pslverr[g]),
        .clk_ena      (clk_ena),
        .tcnt         (tcnt),
        .overflow     (overflow),
        .underflow    (underflow),
        .start_counter(start_counter[g]),
        .up_down      (up_down[g]),
        .enable       (enable[g]),
        .clk_sel      (clk_sel[g]),
        .load         (load[g]),
        .clr_overflow (clr_ovf[g]),
        .clr_underflow(clr_udf[g])
      );
    end
  endgenerate

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[12];
  int   w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One APB transfer on instance d; expectation queued when driven, checked at pready
  task automatic apb(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                     input logic [7:0] erd, input bit eerr, output int waits);
    exp_t e;
    bit   done;
    @(negedge clk);
    psel_v    = 3'b000;
    psel_v[d] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = a;
    pwdata    = wd;
    e.rdata     = erd;
    e.err       = eerr;
    e.cmp_rdata = !wr || eerr;
    sb.push_back(e);
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk); #1;
      if (pready[d]) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("pslverr", {31'd0, pslverr[d]}, {31'd0, e.err});
          if (e.cmp_rdata) chk("prdata", {24'd0, prdata[d]}, {24'd0, e.rdata});
        end
      end else begin
        waits++;
      end
    end
    if (!done) begin
      chk("pready_timeout", 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    @(posedge clk); #1;
    psel_v  = 3'b000;
    penable = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int wv;
    apb(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, wv);
    chk("clr_pulses", {30'd0, clr_udf[vecs[i].dut], clr_ovf[vecs[i].dut]}, {30'd0, vecs[i].clr});
  endtask

  initial begin
    //        dut wr    addr   wdata  rdata  err   clr
    vecs[0]  = '{0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00};
    vecs[1]  = '{0, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, 2'b00};
    vecs[2]  = '{0, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 2'b00};
    vecs[3]  = '{0, 1'b0, 8'h03, 8'h00, 8'h00, 1'b0, 2'b00};
    vecs[4]  = '{0, 1'b1, 8'h03, 8'hFF, 8'h00, 1'b1, 2'b00};
    vecs[5]  = '{0, 1'b0, 8'h07, 8'h00, 8'h00, 1'b1, 2'b00};
    vecs[6]  = '{0, 1'b1, 8'h04, 8'h55, 8'h00, 1'b1, 2'b00};
    vecs[7]  = '{0, 1'b1, 8'h06, 8'h03, 8'h00, 1'b1, 2'b00};
    vecs[8]  = '{0, 1'b0, 8'h00, 8'h00, 8'h0A, 1'b0, 2'b00};
    vecs[9]  = '{0, 1'b0, 8'h03, 8'h00, 8'h5C, 1'b0, 2'b00};
    vecs[10] = '{0, 1'b1, 8'h02, 8'h03, 8'h00, 1'b0, 2'b11};
    vecs[11] = '{0, 1'b0, 8'h02, 8'h00, 8'h03, 1'b0, 2'b00};

    rst_n = 1'b0; psel_v = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; clk_ena = 1'b0;
    overflow = 1'b0; underflow = 1'b0; tcnt = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Reset state
    @(posedge clk); #1;
    chk("rst_pready",  {31'd0, pready[0]}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr[0]}, 32'd0);
    chk("rst_prdata",  {24'd0, prdata[0]}, 32'd0);
    chk("rst_outputs", {load[0], up_down[0], enable[0], clk_sel[0], clr_ovf[0], clr_udf[0], start_counter[0]}, 32'd0);
    for (int i = 0; i < 4; i++) run_vec(i);

    // TDR/TCR programming and the load handshake
    apb(0, 1'b1, 8'h00, 8'h0A, 8'h00, 1'b0, w);
    apb(0, 1'b1, 8'h01, 8'hB0, 8'h00, 1'b0, w);
    chk("start_counter", {24'd0, start_counter[0]}, 32'h0A);
    chk("up_down",       {31'd0, up_down[0]}, 32'd1);
    chk("enable",        {31'd0, enable[0]}, 32'd1);
    chk("clk_sel",       {30'd0, clk_sel[0]}, 32'd0);
    chk("load_set",      {31'd0, load[0]}, 32'd1);
    repeat (2) @(posedge clk);
    #1 chk("load_hold", {31'd0, load[0]}, 32'd1);
    @(negedge clk); clk_ena = 1'b1;
    @(posedge clk); #1;
    chk("load_retire", {31'd0, load[0]}, 32'd0);
    clk_ena = 1'b0;
    apb(0, 1'b0, 8'h01, 8'h00, 8'h30, 1'b0, w);

    // A tick coincident with the setting write does not retire load
    clk_ena = 1'b1;
    apb(0, 1'b1, 8'h01, 8'hB3, 8'h00, 1'b0, w);
    chk("load_same_cycle_tick", {31'd0, load[0]}, 32'd1);
    chk("clk_sel_div16",        {30'd0, clk_sel[0]}, 32'd3);
    @(posedge clk); #1;
    chk("load_next_tick", {31'd0, load[0]}, 32'd0);
    clk_ena = 1'b0;

    // Writing bit 7 = 0 updates fields but keeps a pending load
    apb(0, 1'b1, 8'h01, 8'hB0, 8'h00, 1'b0, w);
    apb(0, 1'b1, 8'h01, 8'h20, 8'h00, 1'b0, w);
    chk("load_not_cancelled", {31'd0, load[0]}, 32'd1);
    chk("enable_cleared",     {31'd0, enable[0]}, 32'd0);
    apb(0, 1'b0, 8'h01, 8'h00, 8'hA0, 1'b0, w);
    @(negedge clk); clk_ena = 1'b1;
    @(negedge clk); clk_ena = 1'b0;
    #1 chk("load_retire2", {31'd0, load[0]}, 32'd0);

    // Status flags and write-1-to-clear pulses
    overflow = 1'b1; underflow = 1'b1;
    apb(0, 1'b0, 8'h02, 8'h00, 8'h03, 1'b0, w);
    apb(0, 1'b1, 8'h02, 8'h01, 8'h00, 1'b0, w);
    chk("clr_overflow_pulse",  {31'd0, clr_ovf[0]}, 32'd1);
    chk("clr_underflow_quiet", {31'd0, clr_udf[0]}, 32'd0);
    @(posedge clk); #1;
    chk("clr_overflow_end", {31'd0, clr_ovf[0]}, 32'd0);

    // Wait states on the WAIT_CYCLES=3 instance
    tcnt = 8'hF5;
    apb(1, 1'b0, 8'h03, 8'h00, 8'hF5, 1'b0, w);
    chk("wait3_cycles", w, 32'd3);

    // Error responses, aliasing and live reads
    tcnt = 8'h5C;
    for (int i = 4; i < 12; i++) run_vec(i);
    chk("tdr_after_errors", {24'd0, start_counter[0]}, 32'h0A);

    // Reset in the ACCESS phase of a TCR write on the WAIT_CYCLES=2 instance
    @(negedge clk);
    psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'hB0;
    @(negedge clk); penable = 1'b1;
    @(posedge clk); #1;
    chk("w2_access_stalled", {31'd0, pready[2]}, 32'd0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; psel_v = 3'b000; penable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_abort_tcr",   {29'd0, up_down[2], enable[2], clk_sel[2]}, 32'd0);
    chk("rst_abort_load",  {31'd0, load[2]}, 32'd0);
    chk("rst_abort_ready", {31'd0, pready[2]}, 32'd0);
    apb(2, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, w);
    chk("wait2_cycles", w, 32'd2);
    apb(2, 1'b1, 8'h00, 8'h77, 8'h00, 1'b0, w);
    chk("post_reset_write", {24'd0, start_counter[2]}, 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
